fighter_sprite_anim: RTL and testbench
======================================

// Module: fighter_sprite_anim
// PURPOSE
//  Parametrised animated fighter sprite engine. It replaces the fixed stand/punch mux with a
//  move-request FSM, per-move multi-frame animation timed off vsync ticks, and horizontal flip.
//  It has a pipelined pixel path that drives an external sync sprite ROM.
//  Sits between game logic (move requests, position, facing) and the VGA colour mapper.
// PARAMETERS
//  NUM_MOVES   4      number of move ids; width MW=$clog2(NUM_MOVES)
//  MAX_FRAMES  4      max animation frames per move; width FW=$clog2(MAX_FRAMES)
//  SPR_W       64     sprite width, pixels
//  SPR_H       96     sprite height, pixels
//  HOLD_TICKS  6      frame_tick pulses per animation frame (>=1)
//  ROM_AW      17     sprite ROM address width
//  KEY_RGB     12'hF0F  transparent colour key
// PORTS
//  vga_clk        in   1       pixel clock, single clock domain
//  reset_n        in   1       asynchronous, active-low reset
//  frame_tick     in   1       1-cycle pulse per vsync
//  move_req       in   MW      requested move id
//  move_req_valid in   1       request strobe, 1 cycle
//  facing_left    in   1       1 = mirror sprite horizontally
//  DrawX, DrawY   in   10      current pixel coordinate
//  PosX, PosY     in   10      sprite top-left corner
//  blank          in   1       0 = blanking interval
//  rom_addr       out  ROM_AW  sprite ROM address (registered)
//  rom_data       in   12      ROM RGB444, valid 1 cycle after rom_addr
//  red,green,blue out  4       pixel colour
//  sprite_on      out  1       opaque sprite pixel present
//  busy           out  1       one-shot move in progress
//  move_cur       out  MW      move currently displayed
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; move=0 (STAND); frame=0; hold counter=0.
//  FSM IDLE: move 0 loops frames 0..LEN[0]-1. Accepts a valid request with move_req<NUM_MOVES:
//   a LOOP move stays in IDLE-class looping; a one-shot move goes to PLAY.
//  FSM PLAY: busy=1; ignores all requests; after the last frame's hold expires, goes to IDLE, move=0, frame=0.
//  Invalid id (>=NUM_MOVES) or request while PLAY: dropped, no state change.
//  Frame advance: hold counter increments on frame_tick. At HOLD_TICKS-1 it clears and frame
//   increments, wrapping to 0 for loop moves.
//  Request accepted in the same cycle as frame_tick: request wins; frame=0; hold=0.
//  Tear-free display: displayed move/frame/facing are shadow registers loaded only on frame_tick.
//   move_cur reflects the shadow value.
//  Pixel pipe (latency 2): S0 relx=DrawX-PosX, rely=DrawY-PosY, 11-bit signed.
//   in_box = 0<=relx<SPR_W and 0<=rely<SPR_H. col = facing ? SPR_W-1-relx : relx.
//  S1: rom_addr = BASE(move,frame)+rely*SPR_W+col, truncated to ROM_AW; in_box and blank delayed.
//  S2: sprite_on = in_box_d2 & blank_d2 & (rom_data!=KEY_RGB). RGB = rom_data when sprite_on, else 0.
//  Out-of-box: rom_addr holds its last value, sprite_on=0.
//  Sprite partly off-screen: clipped pixels are never on; wrap-around is forbidden.
//  Reset asserted mid-animation: immediate return to reset state, pipe flushed.
// STRUCTURE
//  Package fighter_sprite_pkg holds:
//   - move ids (MOVE_STAND=0, MOVE_PUNCH=1, MOVE_JUMP=2, MOVE_KICK=3)
//   - LEN[] frame-count table and LOOP[] flag table
//   - BASE(move,frame) address function
//   - FSM state enum {IDLE,PLAY}
//  Sub-module sprite_pixel_pipe: S0-S2 address gen, flip, colour key.
//  Top holds the FSM and animation counters.
// TESTING
//  Reset, then 24 ticks, HOLD=6, LEN[0]=4 -> move_cur=0; frame cycles 0,1,2,3,0; busy=0.
//  Punch req (LEN=3) -> busy=1 for 18 ticks, then move_cur=0, frame=0; rom_addr base changes only on frame_tick.
//  Jump req during punch, and move_req=NUM_MOVES in IDLE -> both ignored, state unchanged.
//  Req and frame_tick in the same cycle -> new move at frame 0, hold=0.
//  PosX=100, DrawX=100, flip=0 -> col=0; flip=1 -> col=63. rgb appears 2 cycles later.
//   DrawX=99 or 164 -> sprite_on=0.
//  rom_data=KEY_RGB or blank=0 -> sprite_on=0, rgb=0.
//  reset_n low mid-PLAY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fighter_sprite_anim_pkg.sv
// Shared move ids, per-move animation tables, sprite-sheet addressing and FSM states
// for the fighter sprite engine.
package fighter_sprite_pkg;
  localparam int PKG_MOVES = 4;

  typedef enum logic [1:0] {
    MOVE_STAND = 2'd0,
    MOVE_PUNCH = 2'd1,
    MOVE_JUMP  = 2'd2,
    MOVE_KICK  = 2'd3
  } move_e;

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_e;

  localparam int LEN  [PKG_MOVES] = '{4, 3, 4, 3};
  localparam bit LOOP [PKG_MOVES] = '{1'b1, 1'b0, 1'b0, 1'b0};

  // Sheet layout: every move owns MAX_FRAMES consecutive full-size frames.
  function automatic int base_addr(int move, int frame, int max_frames, int frame_px);
    return (move * max_frames + frame) * frame_px;
  endfunction
endpackage

// File: rtl/fighter_sprite_anim_if.sv
// Move-request strobe plus the sync sprite-ROM bus; slave side is the sprite engine.
interface fighter_sprite_anim_if #(
  parameter int RW     = 3,
  parameter int ROM_AW = 17
);
  logic [RW-1:0]     move_req;
  logic              move_req_valid;
  logic [ROM_AW-1:0] rom_addr;
  logic [11:0]       rom_data;

  modport master (output move_req, move_req_valid, rom_data, input rom_addr);
  modport slave  (input move_req, move_req_valid, rom_data, output rom_addr);
endinterface

// File: rtl/fighter_sprite_anim_pixel_pipe.sv
// Two-stage pixel path: box test and flip, ROM address, then colour key on returned data.
module sprite_pixel_pipe
  import fighter_sprite_pkg::*;
#(
  parameter int          SPR_W      = 64,
  parameter int          SPR_H      = 96,
  parameter int          MAX_FRAMES = 4,
  parameter int          ROM_AW     = 17,
  parameter int          MW         = 2,
  parameter int          FW         = 2,
  parameter logic [11:0] KEY_RGB    = 12'hF0F
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              blank,
  input  logic              facing,
  input  logic [MW-1:0]     move,
  input  logic [FW-1:0]     frame,
  input  logic [11:0]       rom_data,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              sprite_on,
  output logic [11:0]       rgb
);
  localparam logic signed [10:0] C_W   = 11'(SPR_W);
  localparam logic signed [10:0] C_H   = 11'(SPR_H);
  localparam logic signed [10:0] C_WM1 = 11'(SPR_W - 1);

  logic signed [10:0] w_relx, w_rely;
  logic [10:0]        w_col;
  logic               w_in_box, w_opaque;
  logic [ROM_AW-1:0]  w_addr, r_rom_addr;
  logic [1:0]         r_vld_pipe;
  logic               r_on;
  logic [11:0]        r_rgb;

  // 11-bit signed offsets keep a sprite hanging off the screen edge from wrapping back in.
  assign w_relx   = $signed({1'b0, draw_x}) - $signed({1'b0, pos_x});
  assign w_rely   = $signed({1'b0, draw_y}) - $signed({1'b0, pos_y});
  assign w_in_box = (w_relx >= 11'sd0) && (w_relx < C_W) && (w_rely >= 11'sd0) && (w_rely < C_H);
  assign w_col    = facing ? 11'(C_WM1 - w_relx) : 11'(w_relx);
  assign w_addr   = ROM_AW'(base_addr(int'(move), int'(frame), MAX_FRAMES, SPR_W * SPR_H)
                            + int'(w_rely) * SPR_W + int'(w_col));
  assign w_opaque = r_vld_pipe[1] && (rom_data != KEY_RGB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
      r_vld_pipe <= '0;
      r_on       <= 1'b0;
      r_rgb      <= '0;
    end else begin
      if (w_in_box) r_rom_addr <= w_addr;
      r_vld_pipe <= {r_vld_pipe[0], w_in_box & blank};
      r_on       <= w_opaque;
      r_rgb      <= w_opaque ? rom_data : 12'h000;
    end
  end

  assign rom_addr  = r_rom_addr;
  assign sprite_on = r_on;
  assign rgb       = r_rgb;
endmodule

// File: rtl/fighter_sprite_anim.sv
// Animated fighter sprite: move-request FSM, vsync-timed frame counters, tear-free
// display shadows and the pixel pipe that drives the external sprite ROM.
module fighter_sprite_anim
  import fighter_sprite_pkg::*;
#(
  parameter int          NUM_MOVES  = 4,
  parameter int          MAX_FRAMES = 4,
  parameter int          SPR_W      = 64,
  parameter int          SPR_H      = 96,
  parameter int          HOLD_TICKS = 6,
  parameter int          ROM_AW     = 17,
  parameter logic [11:0] KEY_RGB    = 12'hF0F,
  localparam int         MW         = $clog2(NUM_MOVES),
  localparam int         FW         = $clog2(MAX_FRAMES)
)(
  input  logic                  vga_clk,
  input  logic                  reset_n,
  input  logic                  frame_tick,
  input  logic                  facing_left,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic [9:0]            PosX,
  input  logic [9:0]            PosY,
  input  logic                  blank,
  fighter_sprite_anim_if.slave  bus,
  output logic [3:0]            red,
  output logic [3:0]            green,
  output logic [3:0]            blue,
  output logic                  sprite_on,
  output logic                  busy,
  output logic [MW-1:0]         move_cur
);
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  state_e        r_state, w_state_nx;
  logic [MW-1:0] r_move, w_move_nx, r_disp_move;
  logic [FW-1:0] r_frame, w_frame_nx, r_disp_frame;
  logic [HW-1:0] r_hold, w_hold_nx;
  logic          r_disp_facing;
  logic          w_req_ok, w_hold_done, w_last_frame;
  logic [11:0]   w_rgb;

  // The request field carries one spare bit so out-of-range ids arrive intact and get dropped.
  assign w_req_ok     = bus.move_req_valid && (r_state == IDLE) && (int'(bus.move_req) < NUM_MOVES);
  assign w_hold_done  = (int'(r_hold) == HOLD_TICKS - 1);
  assign w_last_frame = (int'(r_frame) == LEN[r_move] - 1);

  always_comb begin
    w_state_nx = r_state;
    w_move_nx  = r_move;
    w_frame_nx = r_frame;
    w_hold_nx  = r_hold;
    if (w_req_ok) begin
      w_move_nx  = MW'(bus.move_req);
      w_frame_nx = '0;
      w_hold_nx  = '0;
      w_state_nx = LOOP[MW'(bus.move_req)] ? IDLE : PLAY;
    end else if (frame_tick) begin
      if (!w_hold_done) begin
        w_hold_nx = r_hold + 1'b1;
      end else begin
        w_hold_nx = '0;
        if (!w_last_frame) begin
          w_frame_nx = r_frame + 1'b1;
        end else begin
          w_frame_nx = '0;
          if (r_state == PLAY) begin
            w_state_nx = IDLE;
            w_move_nx  = MW'(MOVE_STAND);
          end
        end
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_move        <= '0;
      r_frame       <= '0;
      r_hold        <= '0;
      r_disp_move   <= '0;
      r_disp_frame  <= '0;
      r_disp_facing <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_move  <= w_move_nx;
      r_frame <= w_frame_nx;
      r_hold  <= w_hold_nx;
      // Display copies only move on vsync so a frame is never drawn half old, half new.
      if (frame_tick) begin
        r_disp_move   <= w_move_nx;
        r_disp_frame  <= w_frame_nx;
        r_disp_facing <= facing_left;
      end
    end
  end

  sprite_pixel_pipe #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .MAX_FRAMES(MAX_FRAMES), .ROM_AW(ROM_AW),
    .MW(MW), .FW(FW), .KEY_RGB(KEY_RGB)
  ) u_pipe (
    .clk(vga_clk), .rst_n(reset_n),
    .draw_x(DrawX), .draw_y(DrawY), .pos_x(PosX), .pos_y(PosY),
    .blank(blank), .facing(r_disp_facing), .move(r_disp_move), .frame(r_disp_frame),
    .rom_data(bus.rom_data), .rom_addr(bus.rom_addr),
    .sprite_on(sprite_on), .rgb(w_rgb)
  );

  assign {red, green, blue} = w_rgb;
  assign busy     = (r_state == PLAY);
  assign move_cur = r_disp_move;
endmodule

// File: tb/tb_fighter_sprite_anim.sv
// Bench for fighter_sprite_anim: pixel vector table, hand-built animation sequences and
// a randomized run against a tick-count reference model.
module tb_fighter_sprite_anim;
  localparam int          HOLD = 6;
  localparam int          FPX  = 64 * 96;
  localparam logic [11:0] KEY  = 12'hF0F;
  localparam int          TLEN [4] = '{4, 3, 4, 3};

  logic       vga_clk = 1'b0, reset_n = 1'b0, frame_tick = 1'b0, facing_left = 1'b0, blank = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, PosX = '0, PosY = '0;
  logic [3:0] red, green, blue;
  logic       sprite_on, busy;
  logic [1:0] move_cur;
  logic       force_key = 1'b0;
  int         n_chk = 0, n_pass = 0;

  fighter_sprite_anim_if #(.RW(3), .ROM_AW(17)) bus();

  fighter_sprite_anim dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .frame_tick(frame_tick), .facing_left(facing_left),
    .DrawX(DrawX), .DrawY(DrawY), .PosX(PosX), .PosY(PosY), .blank(blank), .bus(bus),
    .red(red), .green(green), .blue(blue), .sprite_on(sprite_on), .busy(busy), .move_cur(move_cur)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [11:0] rom_fn(logic [16:0] a);
    logic [11:0] d;
    d = 12'(a * 37 + 5);
    if (d == KEY) d = 12'h123;
    return d;
  endfunction

  always @(posedge vga_clk) bus.rom_data <= force_key ? KEY : rom_fn(bus.rom_addr);

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1; step();
    frame_tick = 1'b0; step();
  endtask

  task automatic park();
    DrawX = 10'd0; DrawY = 10'd0; PosX = 10'd500; PosY = 10'd500;
  endtask

  task automatic origin();
    PosX = 10'd100; PosY = 10'd50; DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1;
  endtask

  task automatic request(int id);
    bus.move_req = 3'(id); bus.move_req_valid = 1'b1; step();
    bus.move_req_valid = 1'b0;
  endtask

  function automatic int rgb_now();
    return int'({red, green, blue});
  endfunction

  // Reference model: animation position is just "ticks since the move started".
  int m_move, m_cnt, m_busy, d_move, d_frame, d_face;
  int p_addr, p_v1, p_v2, p_data, o_on, o_rgb;

  task automatic model_reset();
    m_move = 0; m_cnt = 0; m_busy = 0; d_move = 0; d_frame = 0; d_face = 0;
    p_addr = 0; p_v1 = 0; p_v2 = 0; p_data = 0; o_on = 0; o_rgb = 0;
  endtask

  task automatic model_edge();
    int relx, rely, inb, req;
    o_on   = (p_v2 != 0 && p_data != int'(KEY)) ? 1 : 0;
    o_rgb  = o_on ? p_data : 0;
    p_data = force_key ? int'(KEY) : int'(rom_fn(17'(p_addr)));
    p_v2   = p_v1;
    relx   = int'(DrawX) - int'(PosX);
    rely   = int'(DrawY) - int'(PosY);
    inb    = (relx >= 0 && relx < 64 && rely >= 0 && rely < 96) ? 1 : 0;
    p_v1   = (inb != 0 && blank) ? 1 : 0;
    if (inb != 0) p_addr = (d_move * 4 + d_frame) * FPX + rely * 64 + (d_face ? 63 - relx : relx);
    req = int'(bus.move_req);
    if (bus.move_req_valid && m_busy == 0 && req < 4) begin
      m_move = req; m_cnt = 0; m_busy = (req != 0) ? 1 : 0;
    end else if (frame_tick) begin
      m_cnt++;
      if (m_busy != 0 && m_cnt == TLEN[m_move] * HOLD) begin
        m_move = 0; m_cnt = 0; m_busy = 0;
      end
    end
    if (frame_tick) begin
      d_move = m_move; d_frame = (m_cnt / HOLD) % TLEN[m_move]; d_face = int'(facing_left);
    end
  endtask

  typedef struct {
    int dx, dy, px, py, face, blnk, key, on, addr;
  } vec_t;
  vec_t tbl[13];

  initial begin
    tbl[0]  = '{100,  50,  100, 50, 0, 1, 0, 1, 0};
    tbl[1]  = '{100,  50,  100, 50, 1, 1, 0, 1, 63};
    tbl[2]  = '{163,  50,  100, 50, 0, 1, 0, 1, 63};
    tbl[3]  = '{99,   50,  100, 50, 0, 1, 0, 0, 0};
    tbl[4]  = '{164,  50,  100, 50, 0, 1, 0, 0, 0};
    tbl[5]  = '{100,  145, 100, 50, 0, 1, 0, 1, 6080};
    tbl[6]  = '{100,  146, 100, 50, 0, 1, 0, 0, 0};
    tbl[7]  = '{110,  60,  100, 50, 0, 0, 0, 0, 650};
    tbl[8]  = '{110,  60,  100, 50, 0, 1, 1, 0, 650};
    tbl[9]  = '{10,   0,   1000, 0, 0, 1, 0, 0, 0};
    tbl[10] = '{1023, 0,   1000, 0, 0, 1, 0, 1, 23};
    tbl[11] = '{5,    3,   0,    0, 1, 1, 0, 1, 250};
    tbl[12] = '{100,  49,  100, 50, 0, 1, 0, 0, 0};

    bus.move_req = '0; bus.move_req_valid = 1'b0;
    park();
    step(); step();
    chk("reset rom_addr", int'(bus.rom_addr), 0);
    chk("reset sprite_on", int'(sprite_on), 0);
    chk("reset rgb", rgb_now(), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset move_cur", int'(move_cur), 0);

    // Stand loop: frames 0,1,2,3,0 every six ticks.
    reset_n = 1'b1; origin(); step(); step(); step();
    chk("stand addr f0", int'(bus.rom_addr), 0);
    chk("stand on", int'(sprite_on), 1);
    chk("stand rgb", rgb_now(), int'(rom_fn(17'd0)));
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i % 6 == 0) chk($sformatf("stand addr t%0d", i), int'(bus.rom_addr), ((i / 6) % 4) * FPX);
    end
    chk("stand busy", int'(busy), 0);
    chk("stand move_cur", int'(move_cur), 0);

    // Punch one-shot, with a jump request dropped mid-play.
    request(1);
    chk("punch busy", int'(busy), 1);
    chk("punch shadow move", int'(move_cur), 0);
    step();
    chk("punch addr before tick", int'(bus.rom_addr), 0);
    tick();
    chk("punch move_cur", int'(move_cur), 1);
    chk("punch addr f0", int'(bus.rom_addr), 4 * FPX);
    request(2);
    chk("jump ignored busy", int'(busy), 1);
    for (int i = 2; i <= 17; i++) begin
      tick();
      if (i == 6) chk("punch addr f1", int'(bus.rom_addr), 5 * FPX);
    end
    chk("punch busy t17", int'(busy), 1);
    chk("punch move t17", int'(move_cur), 1);
    chk("punch addr f2", int'(bus.rom_addr), 6 * FPX);
    tick();
    chk("punch done busy", int'(busy), 0);
    chk("punch done move", int'(move_cur), 0);
    chk("punch done addr", int'(bus.rom_addr), 0);

    // Out-of-range id must not restart the stand loop.
    for (int i = 0; i < 3; i++) tick();
    request(4);
    chk("bad id busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) tick();
    chk("bad id addr", int'(bus.rom_addr), FPX);

    // Request coinciding with frame_tick wins, starting at frame 0 hold 0.
    bus.move_req = 3'd3; bus.move_req_valid = 1'b1; frame_tick = 1'b1; step();
    bus.move_req_valid = 1'b0; frame_tick = 1'b0; step();
    chk("kick move_cur", int'(move_cur), 3);
    chk("kick busy", int'(busy), 1);
    chk("kick addr f0", int'(bus.rom_addr), 12 * FPX);
    for (int i = 0; i < 5; i++) tick();
    chk("kick hold f0", int'(bus.rom_addr), 12 * FPX);
    tick();
    chk("kick addr f1", int'(bus.rom_addr), 13 * FPX);
    step();
    chk("kick on", int'(sprite_on), 1);

    // Asynchronous reset mid-play.
    #2 reset_n = 1'b0;
    #1;
    chk("areset busy", int'(busy), 0);
    chk("areset move_cur", int'(move_cur), 0);
    chk("areset rom_addr", int'(bus.rom_addr), 0);
    chk("areset sprite_on", int'(sprite_on), 0);
    chk("areset rgb", rgb_now(), 0);
    step();

    foreach (tbl[i]) begin
      reset_n = 1'b0; park(); blank = 1'b1; force_key = 1'b0; facing_left = 1'(tbl[i].face);
      step();
      reset_n = 1'b1; tick();
      DrawX = 10'(tbl[i].dx); DrawY = 10'(tbl[i].dy); PosX = 10'(tbl[i].px); PosY = 10'(tbl[i].py);
      blank = 1'(tbl[i].blnk); force_key = 1'(tbl[i].key);
      step(); step(); step();
      chk($sformatf("vec%0d rom_addr", i), int'(bus.rom_addr), tbl[i].addr);
      chk($sformatf("vec%0d sprite_on", i), int'(sprite_on), tbl[i].on);
      chk($sformatf("vec%0d rgb", i), rgb_now(), tbl[i].on ? int'(rom_fn(17'(tbl[i].addr))) : 0);
    end
    force_key = 1'b0;

    // Randomized run against the reference model.
    reset_n = 1'b0; park(); frame_tick = 1'b0; bus.move_req_valid = 1'b0; facing_left = 1'b0;
    step();
    reset_n = 1'b1; model_reset();
    PosX = 10'd200; PosY = 10'd150;
    for (int c = 0; c < 1500; c++) begin
      frame_tick = ($urandom_range(0, 3) == 0);
      bus.move_req_valid = ($urandom_range(0, 5) == 0);
      bus.move_req = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) facing_left = ~facing_left;
      if ($urandom_range(0, 63) == 0) begin
        PosX = 10'($urandom_range(0, 1023)); PosY = 10'($urandom_range(0, 1023));
      end
      DrawX = PosX + 10'($urandom_range(0, 80)) - 10'd8;
      DrawY = PosY + 10'($urandom_range(0, 110)) - 10'd8;
      blank = ($urandom_range(0, 7) != 0);
      force_key = ($urandom_range(0, 9) == 0);
      step();
      model_edge();
      chk("rnd rom_addr", int'(bus.rom_addr), p_addr);
      chk("rnd sprite_on", int'(sprite_on), o_on);
      chk("rnd rgb", rgb_now(), o_rgb);
      chk("rnd busy", int'(busy), m_busy);
      chk("rnd move_cur", int'(move_cur), d_move);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
